// File: rtl/psum_acc_ctrl.sv
`default_nettype none
// psum_acc_ctrl: two-stage read-modify-write partial-sum accumulator with memory clear and 2-entry result FIFO.
// Rev 1.0 -- define PSUM_SAT_EN for saturating accumulation (default build wraps modulo 2^ACC_WIDTH).
module psum_acc_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8,
  parameter int CLR_DEPTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_psum,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_first,
  input  logic                  i_last,
  input  logic                  i_clr_start,
  output logic                  o_busy,
  output logic                  o_pm_rd_en,
  output logic [ADDR_WIDTH-1:0] o_pm_rd_addr,
  input  logic [ACC_WIDTH-1:0]  i_pm_rd_data,
  output logic                  o_pm_wr_en,
  output logic [ADDR_WIDTH-1:0] o_pm_wr_addr,
  output logic [ACC_WIDTH-1:0]  o_pm_wr_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ACC_WIDTH-1:0]  o_out_data,
  output logic [ADDR_WIDTH-1:0] o_out_addr
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(CLR_DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;

  logic                    s1_valid;
  logic [DATA_WIDTH-1:0]   s1_psum;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic                    s1_first;
  logic                    s1_last;

  logic [ACC_WIDTH-1:0]    fifo_data [2];
  logic [ADDR_WIDTH-1:0]   fifo_addr [2];
  logic                    fifo_wr_ptr;
  logic                    fifo_rd_ptr;
  logic [1:0]              fifo_cnt;
  logic [1:0]              fifo_occ;

  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [ACC_WIDTH-1:0]    base;
  logic [ACC_WIDTH-1:0]    sum;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_clr_start && !s1_valid) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == CLR_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR)
        clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
    end
  end

  // A stage-1 op with last set reserves a FIFO slot before it is pushed.
  assign fifo_occ = fifo_cnt + {1'b0, s1_valid && s1_last};
  assign o_ready  = (state == IDLE) && !i_clr_start && (fifo_occ < 2'd2);
  assign o_busy   = (state == CLEAR);
  assign accept   = i_valid && o_ready;

  assign o_pm_rd_en   = accept;
  assign o_pm_rd_addr = i_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_psum  <= '0;
      s1_addr  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_psum  <= i_psum;
        s1_addr  <= i_addr;
        s1_first <= i_first;
        s1_last  <= i_last;
      end
    end
  end

  assign base = s1_first ? '0 : i_pm_rd_data;

`ifdef PSUM_SAT_EN
  logic [ACC_WIDTH:0] sum_full;
  always_comb begin
    sum_full = {base[ACC_WIDTH-1], base}
             + {{(ACC_WIDTH+1-DATA_WIDTH){s1_psum[DATA_WIDTH-1]}}, s1_psum};
    // Disagreeing top two bits of the extended sum mean signed overflow.
    if (sum_full[ACC_WIDTH] != sum_full[ACC_WIDTH-1])
      sum = sum_full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sum = sum_full[ACC_WIDTH-1:0];
  end
`else
  assign sum = base + {{(ACC_WIDTH-DATA_WIDTH){s1_psum[DATA_WIDTH-1]}}, s1_psum};
`endif

  assign o_pm_wr_en   = (state == CLEAR) || s1_valid;
  assign o_pm_wr_addr = (state == CLEAR) ? clr_cnt : s1_addr;
  assign o_pm_wr_data = (state == CLEAR) ? '0 : sum;

  assign push        = s1_valid && s1_last;
  assign pop         = o_out_valid && i_out_ready;
  assign o_out_valid = (fifo_cnt != 2'd0);
  assign o_out_data  = fifo_data[fifo_rd_ptr];
  assign o_out_addr  = fifo_addr[fifo_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
      if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data[fifo_wr_ptr] <= sum;
      fifo_addr[fifo_wr_ptr] <= s1_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_acc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_psum_acc_ctrl: directed and randomized self-check of psum_acc_ctrl against a bench-side memory and reference model.
module tb_psum_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ready;
  logic [7:0]  psum, addr;
  logic        first, last;
  logic        clr_start, busy;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [23:0] rd_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        out_valid, out_ready;
  logic [23:0] out_data;
  logic [7:0]  out_addr;

  always #5 clk = ~clk;

  psum_acc_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_psum(psum), .i_addr(addr), .i_first(first), .i_last(last),
    .i_clr_start(clr_start), .o_busy(busy),
    .o_pm_rd_en(rd_en), .o_pm_rd_addr(rd_addr), .i_pm_rd_data(rd_data),
    .o_pm_wr_en(wr_en), .o_pm_wr_addr(wr_addr), .o_pm_wr_data(wr_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_addr(out_addr)
  );

  // Bench-owned psum memory: write-first on a same-address read/write.
  logic [23:0] mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [23:0] poke_data = '0;
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (wr_en)   mem[wr_addr]   <= wr_data;
    if (rd_en)   rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] ref_mem [256];
  logic [23:0] exp_d [$];
  logic [7:0]  exp_a [$];
  logic [23:0] last_d;
  logic [7:0]  last_a;
  int rdy_mode = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_sum(input logic [23:0] b_in, input logic [7:0] p, input logic f);
    longint b, s;
    b = f ? 64'sd0 : longint'($signed(b_in));
    s = b + longint'($signed(p));
`ifdef PSUM_SAT_EN
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
`endif
    return s[23:0];
  endfunction

  // Model and compare process: the memory order of accepts is the order of accumulation.
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_en", {63'd0, rd_en}, {63'd0, valid && ready});
      if (valid && ready) begin
        check("rd_addr", {56'd0, rd_addr}, {56'd0, addr});
        ref_mem[addr] = model_sum(ref_mem[addr], psum, first);
        if (last) begin
          exp_d.push_back(ref_mem[addr]);
          exp_a.push_back(addr);
        end
      end
      if (busy) begin
        check("ready_in_clear", {63'd0, ready}, 64'd0);
        check("clear_wr_data", {40'd0, wr_data}, 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          check("out_unexpected", {63'd0, out_valid}, 64'd0);
        end else begin
          check("out_data", {40'd0, out_data}, {40'd0, exp_d[0]});
          check("out_addr", {56'd0, out_addr}, {56'd0, exp_a[0]});
          last_d = out_data;
          last_a = out_addr;
          void'(exp_d.pop_front());
          void'(exp_a.pop_front());
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] p, input logic f,
                      input logic l, output int stalls);
    valid = 1'b1; addr = a; psum = p; first = f; last = l;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      stalls++;
      if (stalls > 200) begin
        check("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (exp_d.size() == 0 && !out_valid) break;
      t++;
      if (t > 200) begin
        check("drain_timeout", 64'd1, 64'd0);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    int cnt, t;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    cnt = 0;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    check("clear_busy_cycles", cnt, 16);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [23:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic random_burst(input int n);
    int st;
    rdy_mode = 2;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(8'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), st);
    end
    rdy_mode = 1;
    wait_idle();
    for (int a = 0; a < 16; a++) check("mem_final", {40'd0, mem[a]}, {40'd0, ref_mem[a]});
  endtask

  initial begin
    int st, tot, t;
    logic [23:0] exp_sat;
    rst = 1'b1; valid = 1'b0; psum = '0; addr = '0; first = 1'b0; last = 1'b0;
    clr_start = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_out_valid", {63'd0, out_valid}, 0);
    check("rst_wr_en", {63'd0, wr_en}, 0);
    check("rst_rd_en", {63'd0, rd_en}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {63'd0, ready}, 1);
    @(posedge clk); #1;

    do_clear();
    for (int a = 0; a < 16; a++) check("cleared_entry", {40'd0, mem[a]}, 0);

    // Overwrite then accumulate a negative psum.
    send(8'd3, 8'd5, 1'b1, 1'b0, st);
    send(8'd3, 8'hFE, 1'b0, 1'b1, st);
    wait_idle();
    check("acc_out_data", {40'd0, last_d}, 3);
    check("acc_out_addr", {56'd0, last_a}, 3);
    check("acc_mem3", {40'd0, mem[3]}, 3);

    tot = 0;
    for (int k = 0; k < 4; k++) begin
      send(8'd7, 8'd1, (k == 0), (k == 3), st);
      tot += st;
    end
    check("b2b_stalls", tot, 0);
    wait_idle();
    check("b2b_out_data", {40'd0, last_d}, 4);

    // Blocked output: third last-op must wait for FIFO space.
    rdy_mode = 0;
    @(posedge clk); #1;
    send(8'd10, 8'd10, 1'b1, 1'b1, st);
    send(8'd11, 8'd20, 1'b1, 1'b1, st);
    @(negedge clk);
    check("ready_drop_fifo_full", {63'd0, ready}, 0);
    @(posedge clk); #1;
    fork begin repeat (5) @(posedge clk); rdy_mode = 1; end join_none
    send(8'd12, 8'd30, 1'b1, 1'b1, st);
    check("fifo_full_stall", {63'd0, st >= 3}, 1);
    wait_idle();
    check("fifo_order_last", {56'd0, last_a}, 12);
    check("fifo_order_data", {40'd0, last_d}, 30);

`ifdef PSUM_SAT_EN
    exp_sat = 24'h7FFFFF;
`else
    exp_sat = 24'h800000;
`endif
    poke(8'd9, 24'h7FFFFF);
    send(8'd9, 8'd1, 1'b0, 1'b1, st);
    wait_idle();
    check("pos_overflow", {40'd0, last_d}, {40'd0, exp_sat});
    poke(8'd9, 24'h800000);
    send(8'd9, 8'hFF, 1'b0, 1'b1, st);
    wait_idle();
    check("neg_overflow", {40'd0, last_d}, {40'd0, ~exp_sat});

    random_burst(300);

    // Reset in the middle of a clear.
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (wr_en && busy && wr_addr == 8'd5) break;
    end
    check("clear_reached_5", t < 40, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 0);
    check("midrst_wr_en", {63'd0, wr_en}, 0);
    check("midrst_rd_en", {63'd0, rd_en}, 0);
    check("midrst_out_valid", {63'd0, out_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_d.delete();
    exp_a.delete();
    @(negedge clk);
    check("midrst_ready", {63'd0, ready}, 1);
    check("midrst_busy_after", {63'd0, busy}, 0);
    @(posedge clk); #1;
    do_clear();
    random_burst(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/psum_acc_ctrl.md
PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: signed incoming partial-sum width.
REQ-002 Parameter ACC_WIDTH, default 24: signed accumulator and psum memory word width.
REQ-003 Parameter ADDR_WIDTH, default 8: psum memory address width.
REQ-004 Parameter CLR_DEPTH, default 16: number of memory entries zeroed by a clear.
REQ-005 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 i_rst  in  1  asynchronous, active-high reset.
REQ-007 i_valid / o_ready  in / out  1 / 1  upstream handshake; accept = i_valid && o_ready.
REQ-008 i_psum  in  DATA_WIDTH  signed psum; i_addr  in  ADDR_WIDTH  target entry.
REQ-009 i_first / i_last  in  1 / 1  overwrite entry instead of accumulating / emit result after update.
REQ-010 i_clr_start  in  1  pulse that starts zeroing entries 0..CLR_DEPTH-1; o_busy  out  1  clear in progress.
REQ-011 o_pm_rd_en, o_pm_rd_addr  out  1, ADDR_WIDTH  memory read request.
REQ-012 i_pm_rd_data  in  ACC_WIDTH  memory data, valid the cycle after o_pm_rd_en.
REQ-013 o_pm_wr_en, o_pm_wr_addr, o_pm_wr_data  out  1, ADDR_WIDTH, ACC_WIDTH  memory write port.
REQ-014 o_out_valid / i_out_ready  out / in  1 / 1  result handshake; o_out_data  out  ACC_WIDTH; o_out_addr  out  ADDR_WIDTH.

Function
REQ-015 FSM states IDLE, CLEAR; IDLE->CLEAR on i_clr_start while no operation is in stage 1; CLEAR->IDLE after the write to entry CLR_DEPTH-1.
REQ-016 CLEAR: one write per cycle, o_pm_wr_data=0, address counter 0..CLR_DEPTH-1; o_busy=1; o_ready=0.
REQ-017 i_clr_start in CLEAR or while stage 1 is valid SHALL be ignored.
REQ-018 Stage 0 (accept cycle N): o_pm_rd_en=1, o_pm_rd_addr=i_addr combinationally; psum, addr, first, last registered into stage 1.
REQ-019 Stage 1 (cycle N+1): base = first ? 0 : i_pm_rd_data; sum = base + sign-extended psum; o_pm_wr_en=1, o_pm_wr_addr=addr, o_pm_wr_data=sum, all in N+1.
REQ-020 Back-to-back accepts to the same address SHALL accumulate correctly; the read registered at the same edge as the preceding write returns the updated word, so no forwarding is used.
REQ-021 Without saturation, sum wraps modulo 2^ACC_WIDTH.
REQ-022 If stage-1 last=1, {sum, addr} SHALL be pushed into a 2-entry output FIFO at the end of N+1.
REQ-023 o_out_valid = FIFO non-empty; o_out_data/o_out_addr show the head; pop on o_out_valid && i_out_ready.
REQ-024 o_ready = (state==IDLE) && !i_clr_start && (FIFO count + stage-1 pending last < 2); the FIFO SHALL never overflow.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged and preserve order.

Reset
REQ-026 i_rst SHALL force state IDLE, stage 1 invalid, FIFO empty, clear counter 0, o_busy=0, o_out_valid=0, o_pm_wr_en=0, o_pm_rd_en=0; o_ready=1 after release.
REQ-027 Reset mid-CLEAR or mid-operation SHALL abandon it; memory contents are not restored.

Configuration
REQ-028 Macro PSUM_SAT_EN defined: sum SHALL saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; undefined: wrap per REQ-021.

Verification
REQ-029 Clear, then accept addr 3 psum 5 first=1 and psum -2 last=1 -> memory[3]=3; output {3, addr 3}.
REQ-030 Four back-to-back accepts to addr 7 (psum 1; first on the 1st, last on the 4th) -> output 4 with no bubble.
REQ-031 i_out_ready=0 with three last ops -> o_ready drops after two are queued; the FIFO delivers them in order when released.
REQ-032 i_clr_start -> o_busy high for 16 cycles, entries 0..15 read back 0, o_ready=0 throughout.
REQ-033 Entry 0x7FFFFF + psum 1 -> 0x800000 without PSUM_SAT_EN, 0x7FFFFF with it.
REQ-034 Assert i_rst during CLEAR at counter 5 -> all outputs at reset values next cycle; o_busy=0.
